// File: rtl/serial_cfg_master_if.sv
// Bus between serial_cfg_master and its requester/backend: request handshake,
// serial link to the backend and status pulses.
interface serial_cfg_master_if #(
  parameter int FRAME_W = 8
);
  logic               i_req_valid;
  logic               o_req_ready;
  logic [FRAME_W-1:0] i_req_frame;
  logic               o_resetbAll;
  logic               o_sclk;
  logic               o_sdout;
  logic               i_ready;
  logic               o_busy;
  logic               o_done;
  logic               o_timeout;

  modport master (
    input  i_req_valid, i_req_frame, i_ready,
    output o_req_ready, o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout
  );

  modport slave (
    output i_req_valid, i_req_frame, i_ready,
    input  o_req_ready, o_resetbAll, o_sclk, o_sdout, o_busy, o_done, o_timeout
  );
endinterface

// File: rtl/serial_cfg_master.sv
// Serial configuration master: backend reset, MSB-first frame shift, wait for ready.
// Optional macro CFG_PARITY_EN appends an odd-parity bit after the payload LSB.
module serial_cfg_master #(
  parameter int CLK_DIV = 2,
  parameter int FRAME_W = 8,
  parameter int RST_CYC = 16,
  parameter int TIMEOUT = 255
) (
  input  logic                i_clk,
  input  logic                i_rst,
  serial_cfg_master_if.master bus
);

`ifdef CFG_PARITY_EN
  localparam int NBITS = FRAME_W + 1;
`else
  localparam int NBITS = FRAME_W;
`endif

  localparam int DIV_W  = $clog2(2 * CLK_DIV);
  localparam int BIT_W  = $clog2(NBITS);
  localparam int RST_W  = $clog2(RST_CYC + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  localparam logic [DIV_W-1:0]  DIV_HIGH  = DIV_W'(CLK_DIV);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(NBITS - 1);
  localparam logic [RST_W-1:0]  RST_LAST  = RST_W'(RST_CYC - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {BE_RST, IDLE, SHIFT, WAIT_RDY} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [RST_W-1:0]   rst_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic [BIT_W-1:0]   bit_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [NBITS-1:0]   sreg;
  logic [NBITS-1:0]   payload;
  logic               load;
  logic               bit_end;
  logic               ready_hit;
  logic               timeout_hit;
  logic               done_r;
  logic               timeout_r;

`ifdef CFG_PARITY_EN
  // Odd parity: the parity bit makes the total count of ones odd.
  assign payload = {bus.i_req_frame, ~^bus.i_req_frame};
`else
  assign payload = bus.i_req_frame;
`endif

  assign bit_end = (div_cnt == DIV_LAST);

  always_comb begin
    state_nxt   = state;
    load        = 1'b0;
    ready_hit   = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      BE_RST:   if (rst_cnt == RST_LAST) state_nxt = IDLE;
      IDLE: begin
        if (bus.i_req_valid) begin
          state_nxt = SHIFT;
          load      = 1'b1;
        end
      end
      SHIFT:    if (bit_end && (bit_cnt == BIT_LAST)) state_nxt = WAIT_RDY;
      WAIT_RDY: begin
        // A ready seen on the final allowed cycle still counts as success.
        if (bus.i_ready) begin
          state_nxt = IDLE;
          ready_hit = 1'b1;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nxt   = BE_RST;
          timeout_hit = 1'b1;
        end
      end
      default:  state_nxt = BE_RST;
    endcase
  end

  always_comb begin
    bus.o_req_ready = (state == IDLE);
    bus.o_busy      = (state != IDLE);
    bus.o_resetbAll = (state != BE_RST);
    bus.o_sclk      = (state == SHIFT) && (div_cnt >= DIV_HIGH);
    bus.o_sdout     = (state == SHIFT) && sreg[NBITS-1];
    bus.o_done      = done_r;
    bus.o_timeout   = timeout_r;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= BE_RST;
      rst_cnt   <= '0;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      done_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state     <= state_nxt;
      done_r    <= ready_hit;
      timeout_r <= timeout_hit;
      rst_cnt   <= ((state == BE_RST) && (state_nxt == BE_RST)) ? rst_cnt + RST_W'(1) : '0;
      wait_cnt  <= (state == WAIT_RDY) ? wait_cnt + WAIT_W'(1) : '0;
      if (state == SHIFT) begin
        if (bit_end) begin
          div_cnt <= '0;
          bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
      end
    end
  end

  // Frame register carries data only; its output is gated by state, so no reset.
  always_ff @(posedge i_clk) begin
    if (load) begin
      sreg <= payload;
    end else if ((state == SHIFT) && bit_end) begin
      sreg <= {sreg[NBITS-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_serial_cfg_master.sv
// Self-checking bench for serial_cfg_master: randomized frames and ready timing
// against a cycle-indexed reference model of the serial protocol.
module tb_serial_cfg_master;
  localparam int CLK_DIV = 2;
  localparam int FRAME_W = 8;
  localparam int RST_CYC = 16;
  localparam int TIMEOUT = 255;
`ifdef CFG_PARITY_EN
  localparam int NB = FRAME_W + 1;
`else
  localparam int NB = FRAME_W;
`endif
  localparam int BIT_LEN   = 2 * CLK_DIV;
  localparam int SHIFT_LEN = BIT_LEN * NB;

  // Observation vector: {req_ready, busy, resetbAll, sclk, sdout, done, timeout}
  localparam logic [6:0] V_IDLE  = 7'b1010000;
  localparam logic [6:0] V_BERST = 7'b0100000;
  localparam logic [6:0] V_WAIT  = 7'b0110000;
  localparam logic [6:0] V_DONE  = 7'b1010010;
  localparam logic [6:0] V_TMO   = 7'b0100001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  serial_cfg_master_if #(.FRAME_W(FRAME_W)) bus ();

  serial_cfg_master #(
    .CLK_DIV(CLK_DIV),
    .FRAME_W(FRAME_W),
    .RST_CYC(RST_CYC),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] observe();
    return {bus.o_req_ready, bus.o_busy, bus.o_resetbAll, bus.o_sclk,
            bus.o_sdout, bus.o_done, bus.o_timeout};
  endfunction

  // Bit b of the serial stream: payload MSB first, then (if enabled) odd parity.
  function automatic logic exp_bit(input logic [FRAME_W-1:0] f, input int b);
    if (b < FRAME_W) return f[FRAME_W-1-b];
    return ($countones(f) % 2) == 0;
  endfunction

  task automatic backend_reset(input string tag);
    for (int k = 0; k < RST_CYC; k++) begin
      checks++;
      if (observe() !== V_BERST) begin
        errors++;
        $display("FAIL %s_berst cyc %0d got %b want %b", tag, k, observe(), V_BERST);
      end
      tick();
    end
    checks++;
    if (observe() !== V_IDLE) begin
      errors++;
      $display("FAIL %s_idle got %b want %b", tag, observe(), V_IDLE);
    end
  endtask

  // Offers frame f from IDLE and checks every SHIFT cycle; abort_at >= 0 pulses reset there.
  task automatic shift_frame(input logic [FRAME_W-1:0] f, input int abort_at, input string tag);
    logic [6:0] exp;
    logic       sclk_e;
    logic       sdo_e;
    checks++;
    if (observe() !== V_IDLE) begin
      errors++;
      $display("FAIL %s_pre_idle got %b want %b", tag, observe(), V_IDLE);
    end
    bus.i_req_valid = 1'b1;
    bus.i_req_frame = f;
    tick();
    for (int c = 0; c < SHIFT_LEN; c++) begin
      bus.i_req_valid = 1'($urandom_range(0, 1));
      bus.i_req_frame = FRAME_W'($urandom);
      sclk_e = (c % BIT_LEN) >= CLK_DIV;
      sdo_e  = exp_bit(f, c / BIT_LEN);
      exp    = {3'b011, sclk_e, sdo_e, 2'b00};
      checks++;
      if (observe() !== exp) begin
        errors++;
        $display("FAIL %s_shift cyc %0d got %b want %b", tag, c, observe(), exp);
      end
      if (c == abort_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.i_req_valid = 1'b0;
        return;
      end
      tick();
    end
    bus.i_req_valid = 1'b0;
  endtask

  // ready_at: WAIT_RDY cycle index where i_ready rises (-1 = never).
  task automatic wait_phase(input int ready_at, input string tag);
    logic [6:0] exp;
    bit         ready_wins;
    int         end_idx;
    ready_wins = (ready_at >= 0) && (ready_at < TIMEOUT);
    end_idx    = ready_wins ? ready_at + 1 : TIMEOUT + RST_CYC;
    for (int idx = 0; idx <= end_idx; idx++) begin
      bus.i_ready = (ready_at >= 0) && (idx >= ready_at);
      if (ready_wins)           exp = (idx == end_idx) ? V_DONE : V_WAIT;
      else if (idx < TIMEOUT)   exp = V_WAIT;
      else if (idx == TIMEOUT)  exp = V_TMO;
      else if (idx < end_idx)   exp = V_BERST;
      else                      exp = V_IDLE;
      checks++;
      if (observe() !== exp) begin
        errors++;
        $display("FAIL %s_wait idx %0d got %b want %b", tag, idx, observe(), exp);
      end
      if (idx < end_idx) begin
        bus.i_req_valid = 1'($urandom_range(0, 1));
        tick();
      end
    end
    bus.i_req_valid = 1'b0;
    bus.i_ready     = 1'b0;
    tick();
    checks++;
    if (observe() !== V_IDLE) begin
      errors++;
      $display("FAIL %s_post_idle got %b want %b", tag, observe(), V_IDLE);
    end
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.i_req_valid = 1'b0;
    bus.i_req_frame = '0;
    bus.i_ready     = 1'b0;
    tick();
    checks++;
    if (observe() !== V_BERST) begin
      errors++;
      $display("FAIL reset_held got %b want %b", observe(), V_BERST);
    end
    tick();
    rst = 1'b0;
    backend_reset("reset");
  endtask

  task automatic test_frame_a5();
    shift_frame(8'hA5, -1, "a5");
    wait_phase(10, "a5");
  endtask

  task automatic test_timeout();
    shift_frame(FRAME_W'($urandom), -1, "tmo");
    wait_phase(-1, "tmo");
  endtask

  task automatic test_ready_tie();
    shift_frame(FRAME_W'($urandom), -1, "tie");
    wait_phase(TIMEOUT - 1, "tie");
    shift_frame(FRAME_W'($urandom), -1, "late");
    wait_phase(TIMEOUT, "late");
  endtask

  task automatic test_mid_shift_reset();
    int at;
    at = 3 * BIT_LEN + $urandom_range(0, BIT_LEN - 1);
    shift_frame(FRAME_W'($urandom), at, "abort");
    backend_reset("abort");
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (observe() !== V_IDLE) begin
        errors++;
        $display("FAIL abort_stay_idle cyc %0d got %b want %b", k, observe(), V_IDLE);
      end
    end
    shift_frame(FRAME_W'($urandom), -1, "after_abort");
    wait_phase($urandom_range(0, 20), "after_abort");
  endtask

  task automatic test_parity();
    shift_frame(8'h03, -1, "par03");
    wait_phase(0, "par03");
    shift_frame(8'h07, -1, "par07");
    wait_phase(3, "par07");
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 12; n++) begin
      shift_frame(FRAME_W'($urandom), -1, "b2b");
      wait_phase($urandom_range(0, 30), "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_frame_a5();
    test_timeout();
    test_ready_tie();
    test_mid_shift_reset();
    test_parity();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
